// File: rtl/chan_hold_pkg.sv
// Shared types and helpers for the multi-channel hold array.
// Channel selection is done over a fixed 32-bit vector so one function serves any CHANNELS <= 32.
package chan_hold_pkg;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_HOLD_MAX = 15;
    localparam int CHAN_W       = $clog2(DEF_CHANNELS);
    localparam int AGE_W        = $clog2(DEF_HOLD_MAX + 1);
    localparam int MAX_CHANNELS = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } sel_t;

    function automatic sel_t lowest_set(input logic [MAX_CHANNELS-1:0] vec);
        sel_t r;
        r = '0;
        for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = 5'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/chan_hold_slot.sv
// One channel: staging register, held output register, pending flag and saturating age counter.
// load and commit are never asserted together (load only in IDLE, commit only in COMMIT).
module chan_hold_slot
    import chan_hold_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               HOLD_MAX  = DEF_HOLD_MAX,
    parameter int               AGE_BITS  = AGE_W
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             commit,
    output logic             pending,
    output logic [WIDTH-1:0] held,
    output logic             upd,
    output logic             stale
);

    logic [WIDTH-1:0]    staging;
    logic [AGE_BITS-1:0] age;

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            staging <= RESET_VAL;
            held    <= RESET_VAL;
            pending <= 1'b0;
            upd     <= 1'b0;
            age     <= '0;
        end else begin
            if (load) begin
                staging <= load_data;
            end
            if (commit) begin
                held    <= staging;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
            // commit is already gated by en upstream, so upd drops to 0 while en is low
            upd <= commit;
            if (en) begin
                if (commit) begin
                    age <= '0;
                end else if (age != AGE_BITS'(HOLD_MAX)) begin
                    age <= age + 1'b1;
                end
            end
        end
    end

    assign stale = (age == AGE_BITS'(HOLD_MAX));

endmodule

// File: rtl/chan_hold_array.sv
// Multi-channel staged hold: writes land in staging, a commit pass copies pending channels
// to the held outputs one per cycle, lowest index first.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | accepting writes; waits for a commit request while en high
//   COMMIT | transferring one pending channel per enabled cycle
module chan_hold_array
    import chan_hold_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CHANNELS  = DEF_CHANNELS,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               HOLD_MAX  = DEF_HOLD_MAX
) (
    input  logic                        i_clk,
    input  logic                        i_arst,
    input  logic                        en,
    input  logic                        i_wr_valid,
    output logic                        o_wr_ready,
    input  logic [$clog2(CHANNELS)-1:0] i_wr_chan,
    input  logic [WIDTH-1:0]            i_wr_data,
    input  logic                        i_commit,
    output logic                        o_busy,
    output logic [CHANNELS*WIDTH-1:0]   o_data,
    output logic [CHANNELS-1:0]         o_upd,
    output logic [CHANNELS-1:0]         o_stale
);

    localparam int SEL_W    = $clog2(CHANNELS);
    localparam int AGE_BITS = $clog2(HOLD_MAX + 1);

    state_t                  state, state_nxt;
    logic                    commit_req;
    logic                    enter_commit;
    logic                    wr_fire;
    logic [CHANNELS-1:0]     pending;
    logic [CHANNELS-1:0]     load_vec;
    logic [CHANNELS-1:0]     commit_stb;
    logic [MAX_CHANNELS-1:0] pend_ext;
    sel_t                    sel;

    assign o_wr_ready = en && (state == IDLE);
    assign o_busy     = (state == COMMIT);
    // Out-of-range channels are still accepted, just discarded
    assign wr_fire    = i_wr_valid && o_wr_ready && (int'(i_wr_chan) < CHANNELS);
    assign pend_ext   = MAX_CHANNELS'(pending);
    assign sel        = lowest_set(pend_ext);

    always_comb begin
        state_nxt    = state;
        commit_stb   = '0;
        enter_commit = 1'b0;
        case (state)
            IDLE: begin
                if (en && (commit_req || i_commit)) begin
                    state_nxt    = COMMIT;
                    enter_commit = 1'b1;
                end
            end
            COMMIT: begin
                if (en) begin
                    if (sel.found) begin
                        commit_stb = CHANNELS'(1) << sel.idx;
                    end
                    if ((pending & ~commit_stb) == '0) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state      <= IDLE;
            commit_req <= 1'b0;
        end else begin
            state <= state_nxt;
            if (enter_commit) begin
                commit_req <= 1'b0;
            end else if (i_commit) begin
                commit_req <= 1'b1;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_slot
        assign load_vec[c] = wr_fire && (i_wr_chan == SEL_W'(c));

        chan_hold_slot #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL),
            .HOLD_MAX  (HOLD_MAX),
            .AGE_BITS  (AGE_BITS)
        ) u_slot (
            .i_clk     (i_clk),
            .i_arst    (i_arst),
            .en        (en),
            .load      (load_vec[c]),
            .load_data (i_wr_data),
            .commit    (commit_stb[c]),
            .pending   (pending[c]),
            .held      (o_data[c*WIDTH +: WIDTH]),
            .upd       (o_upd[c]),
            .stale     (o_stale[c])
        );
    end

endmodule

// File: tb/tb_chan_hold_array.sv
// Directed bench for chan_hold_array with 4 channels x 8 bits and HOLD_MAX = 3.
module tb_chan_hold_array;

    logic        i_clk = 1'b0;
    logic        i_arst;
    logic        en;
    logic        i_wr_valid;
    logic        o_wr_ready;
    logic [1:0]  i_wr_chan;
    logic [7:0]  i_wr_data;
    logic        i_commit;
    logic        o_busy;
    logic [31:0] o_data;
    logic [3:0]  o_upd;
    logic [3:0]  o_stale;

    int checks = 0;
    int errors = 0;

    chan_hold_array #(
        .WIDTH     (8),
        .CHANNELS  (4),
        .RESET_VAL (8'h00),
        .HOLD_MAX  (3)
    ) dut (
        .i_clk      (i_clk),
        .i_arst     (i_arst),
        .en         (en),
        .i_wr_valid (i_wr_valid),
        .o_wr_ready (o_wr_ready),
        .i_wr_chan  (i_wr_chan),
        .i_wr_data  (i_wr_data),
        .i_commit   (i_commit),
        .o_busy     (o_busy),
        .o_data     (o_data),
        .o_upd      (o_upd),
        .o_stale    (o_stale)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic do_write(input logic [1:0] chan, input logic [7:0] data);
        i_wr_valid = 1'b1;
        i_wr_chan  = chan;
        i_wr_data  = data;
        tick();
        i_wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_arst = 1'b0;
        @(negedge i_clk);
        i_arst = 1'b1;
        checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want %h", o_data, 32'h0); end
        checks++; if (o_upd !== 4'b0) begin errors++; $display("FAIL reset_upd got %b want %b", o_upd, 4'b0); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want %b", o_busy, 1'b0); end
        checks++; if (o_stale !== 4'b0) begin errors++; $display("FAIL reset_stale got %b want %b", o_stale, 4'b0); end
        checks++; if (o_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want %b", o_wr_ready, 1'b1); end
        tick(); tick();
        checks++; if (o_stale !== 4'b0000) begin errors++; $display("FAIL stale_age2 got %b want %b", o_stale, 4'b0000); end
        tick();
        checks++; if (o_stale !== 4'b1111) begin errors++; $display("FAIL stale_age3 got %b want %b", o_stale, 4'b1111); end
    endtask

    task automatic test_commit_two();
        do_write(2'd2, 8'hA5);
        do_write(2'd0, 8'h3C);
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL two_busy0 got %b want %b", o_busy, 1'b1); end
        checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL two_data0 got %h want %h", o_data, 32'h0); end
        tick();
        checks++; if (o_data !== 32'h0000003C) begin errors++; $display("FAIL two_data1 got %h want %h", o_data, 32'h0000003C); end
        checks++; if (o_upd !== 4'b0001) begin errors++; $display("FAIL two_upd1 got %b want %b", o_upd, 4'b0001); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL two_busy1 got %b want %b", o_busy, 1'b1); end
        tick();
        checks++; if (o_data !== 32'h00A5003C) begin errors++; $display("FAIL two_data2 got %h want %h", o_data, 32'h00A5003C); end
        checks++; if (o_upd !== 4'b0100) begin errors++; $display("FAIL two_upd2 got %b want %b", o_upd, 4'b0100); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL two_busy2 got %b want %b", o_busy, 1'b0); end
        checks++; if (o_stale !== 4'b1010) begin errors++; $display("FAIL two_stale got %b want %b", o_stale, 4'b1010); end
        tick();
        checks++; if (o_upd !== 4'b0000) begin errors++; $display("FAIL two_upd3 got %b want %b", o_upd, 4'b0000); end
    endtask

    task automatic test_write_with_commit();
        i_wr_valid = 1'b1;
        i_wr_chan  = 2'd3;
        i_wr_data  = 8'h77;
        i_commit   = 1'b1;
        checks++; if (o_wr_ready !== 1'b1) begin errors++; $display("FAIL same_ready_idle got %b want %b", o_wr_ready, 1'b1); end
        tick();
        i_wr_valid = 1'b0;
        i_commit   = 1'b0;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL same_busy got %b want %b", o_busy, 1'b1); end
        checks++; if (o_wr_ready !== 1'b0) begin errors++; $display("FAIL same_ready_busy got %b want %b", o_wr_ready, 1'b0); end
        tick();
        checks++; if (o_data !== 32'h77A5003C) begin errors++; $display("FAIL same_data got %h want %h", o_data, 32'h77A5003C); end
        checks++; if (o_upd !== 4'b1000) begin errors++; $display("FAIL same_upd got %b want %b", o_upd, 4'b1000); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL same_busy_end got %b want %b", o_busy, 1'b0); end
    endtask

    task automatic test_en_stall();
        do_write(2'd0, 8'h11);
        do_write(2'd1, 8'h22);
        do_write(2'd3, 8'h33);
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        tick();
        checks++; if (o_data !== 32'h77A50011) begin errors++; $display("FAIL stall_first got %h want %h", o_data, 32'h77A50011); end
        checks++; if (o_upd !== 4'b0001) begin errors++; $display("FAIL stall_first_upd got %b want %b", o_upd, 4'b0001); end
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL stall_busy[%0d] got %b want %b", i, o_busy, 1'b1); end
            checks++; if (o_upd !== 4'b0000) begin errors++; $display("FAIL stall_upd[%0d] got %b want %b", i, o_upd, 4'b0000); end
            checks++; if (o_stale !== 4'b1110) begin errors++; $display("FAIL stall_stale[%0d] got %b want %b", i, o_stale, 4'b1110); end
            checks++; if (o_data !== 32'h77A50011) begin errors++; $display("FAIL stall_data[%0d] got %h want %h", i, o_data, 32'h77A50011); end
        end
        en = 1'b1;
        tick();
        checks++; if (o_data !== 32'h77A52211) begin errors++; $display("FAIL resume1_data got %h want %h", o_data, 32'h77A52211); end
        checks++; if (o_upd !== 4'b0010) begin errors++; $display("FAIL resume1_upd got %b want %b", o_upd, 4'b0010); end
        checks++; if (o_stale !== 4'b1100) begin errors++; $display("FAIL resume1_stale got %b want %b", o_stale, 4'b1100); end
        tick();
        checks++; if (o_data !== 32'h33A52211) begin errors++; $display("FAIL resume2_data got %h want %h", o_data, 32'h33A52211); end
        checks++; if (o_upd !== 4'b1000) begin errors++; $display("FAIL resume2_upd got %b want %b", o_upd, 4'b1000); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL resume2_busy got %b want %b", o_busy, 1'b0); end
        checks++; if (o_stale !== 4'b0100) begin errors++; $display("FAIL resume2_stale got %b want %b", o_stale, 4'b0100); end
        tick();
        checks++; if (o_stale !== 4'b0101) begin errors++; $display("FAIL resume3_stale got %b want %b", o_stale, 4'b0101); end
    endtask

    task automatic test_commit_while_busy();
        do_write(2'd1, 8'h44);
        i_commit = 1'b1;
        tick();
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rebusy_enter got %b want %b", o_busy, 1'b1); end
        tick();
        i_commit = 1'b0;
        checks++; if (o_data !== 32'h33A54411) begin errors++; $display("FAIL rebusy_data got %h want %h", o_data, 32'h33A54411); end
        checks++; if (o_upd !== 4'b0010) begin errors++; $display("FAIL rebusy_upd got %b want %b", o_upd, 4'b0010); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rebusy_idle got %b want %b", o_busy, 1'b0); end
        tick();
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL empty_busy got %b want %b", o_busy, 1'b1); end
        checks++; if (o_upd !== 4'b0000) begin errors++; $display("FAIL empty_upd0 got %b want %b", o_upd, 4'b0000); end
        tick();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL empty_end got %b want %b", o_busy, 1'b0); end
        checks++; if (o_upd !== 4'b0000) begin errors++; $display("FAIL empty_upd1 got %b want %b", o_upd, 4'b0000); end
        checks++; if (o_data !== 32'h33A54411) begin errors++; $display("FAIL empty_data got %h want %h", o_data, 32'h33A54411); end
        do_write(2'd3, 8'h5A);
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        tick();
        checks++; if (o_data !== 32'h5AA54411) begin errors++; $display("FAIL late_wr_data got %h want %h", o_data, 32'h5AA54411); end
        checks++; if (o_upd !== 4'b1000) begin errors++; $display("FAIL late_wr_upd got %b want %b", o_upd, 4'b1000); end
    endtask

    task automatic test_async_reset();
        do_write(2'd0, 8'h99);
        do_write(2'd2, 8'h88);
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        tick();
        checks++; if (o_data !== 32'h5AA54499) begin errors++; $display("FAIL arst_pre_data got %h want %h", o_data, 32'h5AA54499); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy got %b want %b", o_busy, 1'b1); end
        #2 i_arst = 1'b0;
        #1;
        checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL arst_data got %h want %h", o_data, 32'h0); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want %b", o_busy, 1'b0); end
        checks++; if (o_upd !== 4'b0000) begin errors++; $display("FAIL arst_upd got %b want %b", o_upd, 4'b0000); end
        checks++; if (o_stale !== 4'b0000) begin errors++; $display("FAIL arst_stale got %b want %b", o_stale, 4'b0000); end
        #1 i_arst = 1'b1;
        @(negedge i_clk);
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL post_busy got %b want %b", o_busy, 1'b1); end
        tick();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL post_busy_end got %b want %b", o_busy, 1'b0); end
        checks++; if (o_upd !== 4'b0000) begin errors++; $display("FAIL post_upd got %b want %b", o_upd, 4'b0000); end
        checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL post_data got %h want %h", o_data, 32'h0); end
    endtask

    initial begin
        i_arst     = 1'b0;
        en         = 1'b1;
        i_wr_valid = 1'b0;
        i_wr_chan  = 2'd0;
        i_wr_data  = 8'h00;
        i_commit   = 1'b0;
        test_reset();
        test_commit_two();
        test_write_with_commit();
        test_en_stall();
        test_commit_while_busy();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
